// File: rtl/soml_decoder.sv
// Slot-wise SOML detector: 4x4 MIMO, two 16-QAM symbols over two slots, 16 antenna-pair candidates.
// Define SOML_METRIC_OUT_EN to add the min_metric output port.
module soml_decoder #(
  parameter int unsigned Q = 22,
  parameter int unsigned N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                H_in_valid,
  input  logic signed [N-1:0] H_in_r,
  input  logic signed [N-1:0] H_in_i,
  input  logic                Y_in_valid,
  input  logic signed [N-1:0] Y_in_r,
  input  logic signed [N-1:0] Y_in_i,
  output logic                output_valid,
  output logic [N-1:0]        s_I_1,
  output logic [N-1:0]        s_Q_1,
  output logic [N-1:0]        s_I_2,
  output logic [N-1:0]        s_Q_2,
  output logic [4:0]          Smin_index,
  output logic [11:0]         signal_out_12bit
`ifdef SOML_METRIC_OUT_EN
  ,
  output logic [2*N+3:0]      min_metric
`endif
);

  localparam int unsigned AW = 2*N + 4;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;
  typedef enum logic [1:0] {PH_ZP, PH_SLICE, PH_MET, PH_SRCH} phase_t;

  function automatic logic signed [AW-1:0] mulq(input logic signed [AW-1:0] a,
                                                input logic signed [AW-1:0] b);
    logic signed [AW-1:0] p;
    p = a * b;
    return p >>> Q;
  endfunction

  // Gray code per component: 00=-3, 01=-1, 11=+1, 10=+3
  function automatic logic [1:0] slice(input logic signed [AW-1:0] v,
                                       input logic signed [AW-1:0] p);
    logic signed [AW-1:0] p2;
    p2 = p <<< 1;
    if (v >= p2)          return 2'b10;
    else if (!v[AW-1])    return 2'b11;
    else if (v >= -p2)    return 2'b01;
    else                  return 2'b00;
  endfunction

  function automatic logic signed [AW-1:0] lvl(input logic [1:0] code);
    logic signed [AW-1:0] m;
    m = code[0] ? (AW'(1) << Q) : (AW'(3) << Q);
    return code[1] ? m : -m;
  endfunction

  state_t               state;
  phase_t               phase;
  logic signed [N-1:0]  hr [4][4];
  logic signed [N-1:0]  hi [4][4];
  logic signed [N-1:0]  yr [4][2];
  logic signed [N-1:0]  yi [4][2];
  logic [4:0]           hcnt;
  logic [3:0]           ycnt;
  logic [2:0]           combo;
  logic [1:0]           row;
  logic [3:0]           sq;
  logic signed [AW-1:0] zr_acc, zi_acc, p_acc, m_acc;
  logic [1:0]           cur_i, cur_q;
  logic [1:0]           ci [2][4];
  logic [1:0]           cq [2][4];
  logic [AW-1:0]        met [2][4];
  logic [AW-1:0]        best;
  logic [3:0]           bidx;

  logic [1:0]           col;
  logic                 slot;
  logic signed [AW-1:0] hx_r, hx_i, yx_r, yx_i, sv_r, sv_i, e_r, e_i;
  logic signed [AW-1:0] term_zr, term_zi, term_p, m_sum;
  logic [AW-1:0]        cand, nbest;
  logic [3:0]           nidx;
  logic                 take;

  // Per-column partial terms: metric separates into slot-0 and slot-1 sums over columns a and b
  always_comb begin
    col     = combo[2:1];
    slot    = combo[0];
    hx_r    = hr[row][col];
    hx_i    = hi[row][col];
    yx_r    = yr[row][slot];
    yx_i    = yi[row][slot];
    sv_r    = lvl(cur_i);
    sv_i    = lvl(cur_q);
    term_zr = mulq(hx_r, yx_r) + mulq(hx_i, yx_i);
    term_zi = mulq(hx_r, yx_i) - mulq(hx_i, yx_r);
    term_p  = mulq(hx_r, hx_r) + mulq(hx_i, hx_i);
    e_r     = yx_r - (mulq(hx_r, sv_r) - mulq(hx_i, sv_i));
    e_i     = yx_i - (mulq(hx_r, sv_i) + mulq(hx_i, sv_r));
    m_sum   = mulq(e_r, e_r) + mulq(e_i, e_i) + ((row == 2'd0) ? '0 : m_acc);
    cand    = met[0][sq[3:2]] + met[1][sq[1:0]];
    take    = (sq == 4'd0) || (cand < best);
    nbest   = take ? cand : best;
    nidx    = take ? sq : bidx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      phase <= PH_ZP;
      hcnt <= '0;
      ycnt <= '0;
      combo <= '0;
      row <= '0;
      sq <= '0;
      zr_acc <= '0;
      zi_acc <= '0;
      p_acc <= '0;
      m_acc <= '0;
      cur_i <= '0;
      cur_q <= '0;
      best <= '0;
      bidx <= '0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          hr[i][j] <= '0;
          hi[i][j] <= '0;
        end
        for (int t = 0; t < 2; t++) begin
          yr[i][t] <= '0;
          yi[i][t] <= '0;
          ci[t][i] <= '0;
          cq[t][i] <= '0;
          met[t][i] <= '0;
        end
      end
      output_valid <= 1'b0;
      s_I_1 <= '0;
      s_Q_1 <= '0;
      s_I_2 <= '0;
      s_Q_2 <= '0;
      Smin_index <= '0;
      signal_out_12bit <= '0;
`ifdef SOML_METRIC_OUT_EN
      min_metric <= '0;
`endif
    end else if (start) begin
      state <= LOAD;
      hcnt <= '0;
      ycnt <= '0;
      output_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          hr[i][j] <= '0;
          hi[i][j] <= '0;
        end
        for (int t = 0; t < 2; t++) begin
          yr[i][t] <= '0;
          yi[i][t] <= '0;
        end
      end
    end else begin
      case (state)
        LOAD: begin
          if (H_in_valid && hcnt < 5'd16) begin
            hr[hcnt[3:2]][hcnt[1:0]] <= H_in_r;
            hi[hcnt[3:2]][hcnt[1:0]] <= H_in_i;
            hcnt <= hcnt + 5'd1;
          end
          if (Y_in_valid && ycnt < 4'd8) begin
            yr[ycnt[2:1]][ycnt[0]] <= Y_in_r;
            yi[ycnt[2:1]][ycnt[0]] <= Y_in_i;
            ycnt <= ycnt + 4'd1;
          end
          if (hcnt == 5'd16 && ycnt == 4'd8) begin
            state <= COMPUTE;
            phase <= PH_ZP;
            combo <= '0;
            row <= '0;
          end
        end
        COMPUTE: begin
          case (phase)
            PH_ZP: begin
              zr_acc <= term_zr + ((row == 2'd0) ? '0 : zr_acc);
              zi_acc <= term_zi + ((row == 2'd0) ? '0 : zi_acc);
              p_acc  <= term_p + ((row == 2'd0) ? '0 : p_acc);
              row <= row + 2'd1;
              if (row == 2'd3) phase <= PH_SLICE;
            end
            PH_SLICE: begin
              cur_i <= slice(zr_acc, p_acc);
              cur_q <= slice(zi_acc, p_acc);
              ci[slot][col] <= slice(zr_acc, p_acc);
              cq[slot][col] <= slice(zi_acc, p_acc);
              phase <= PH_MET;
              row <= '0;
            end
            PH_MET: begin
              m_acc <= m_sum;
              row <= row + 2'd1;
              if (row == 2'd3) begin
                met[slot][col] <= m_sum;
                combo <= combo + 3'd1;
                sq <= '0;
                phase <= (combo == 3'd7) ? PH_SRCH : PH_ZP;
              end
            end
            default: begin
              // strict less-than keeps the lowest q on ties
              best <= nbest;
              bidx <= nidx;
              sq <= sq + 4'd1;
              if (sq == 4'd15) begin
                state <= DONE;
                output_valid <= 1'b1;
                s_I_1 <= N'(lvl(ci[0][nidx[3:2]]));
                s_Q_1 <= N'(lvl(cq[0][nidx[3:2]]));
                s_I_2 <= N'(lvl(ci[1][nidx[1:0]]));
                s_Q_2 <= N'(lvl(cq[1][nidx[1:0]]));
                Smin_index <= {1'b0, nidx};
                signal_out_12bit <= {nidx, ci[0][nidx[3:2]], cq[0][nidx[3:2]],
                                     ci[1][nidx[1:0]], cq[1][nidx[1:0]]};
`ifdef SOML_METRIC_OUT_EN
                min_metric <= nbest;
`endif
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soml_decoder.sv
// Directed bench for soml_decoder with hand-computed expected detections.
module tb_soml_decoder;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        H_in_valid, Y_in_valid;
  logic [31:0] H_in_r, H_in_i, Y_in_r, Y_in_i;
  logic        output_valid;
  logic [31:0] s_I_1, s_Q_1, s_I_2, s_Q_2;
  logic [4:0]  Smin_index;
  logic [11:0] signal_out_12bit;
`ifdef SOML_METRIC_OUT_EN
  logic [67:0] min_metric;
`endif

  soml_decoder dut (
    .clk(clk), .rst(rst), .start(start),
    .H_in_valid(H_in_valid), .H_in_r(H_in_r), .H_in_i(H_in_i),
    .Y_in_valid(Y_in_valid), .Y_in_r(Y_in_r), .Y_in_i(Y_in_i),
    .output_valid(output_valid),
    .s_I_1(s_I_1), .s_Q_1(s_Q_1), .s_I_2(s_I_2), .s_Q_2(s_Q_2),
    .Smin_index(Smin_index), .signal_out_12bit(signal_out_12bit)
`ifdef SOML_METRIC_OUT_EN
    , .min_metric(min_metric)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] P1 = 32'h0040_0000;
  localparam logic [31:0] P3 = 32'h00C0_0000;
  localparam logic [31:0] M1 = 32'hFFC0_0000;
  localparam logic [31:0] M3 = 32'hFF40_0000;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] th_r [16];
  logic [31:0] th_i [16];
  logic [31:0] ty_r [8];
  logic [31:0] ty_i [8];

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_identity();
    for (int n = 0; n < 16; n++) begin
      th_r[n] = ((n >> 2) == (n & 3)) ? P1 : 32'h0;
      th_i[n] = 32'h0;
    end
  endtask

  task automatic set_y(input logic [31:0] b4r, input logic [31:0] b4i,
                       input logic [31:0] b3r, input logic [31:0] b3i);
    for (int k = 0; k < 8; k++) begin
      ty_r[k] = 32'h0;
      ty_i[k] = 32'h0;
    end
    ty_r[4] = b4r; ty_i[4] = b4i;
    ty_r[3] = b3r; ty_i[3] = b3i;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic load(input int ydly, input bit extra_h);
    int last;
    last = (ydly + 8 > 17) ? ydly + 8 : 17;
    for (int c = 0; c < last; c++) begin
      @(negedge clk);
      H_in_valid = 1'b0;
      Y_in_valid = 1'b0;
      if (c < 16) begin
        H_in_valid = 1'b1; H_in_r = th_r[c]; H_in_i = th_i[c];
      end else if (extra_h && c == 16) begin
        H_in_valid = 1'b1; H_in_r = 32'h7FFF_FFFF; H_in_i = 32'h8000_0000;
      end
      if (c >= ydly && c < ydly + 8) begin
        Y_in_valid = 1'b1; Y_in_r = ty_r[c - ydly]; Y_in_i = ty_i[c - ydly];
      end
    end
    @(negedge clk);
    H_in_valid = 1'b0;
    Y_in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!output_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check(tag, 68'(lat <= 256), 68'd1);
  endtask

  task automatic check_res(input string tag, input logic [4:0] idx,
                           input logic [31:0] i1, input logic [31:0] q1,
                           input logic [31:0] i2, input logic [31:0] q2,
                           input logic [11:0] bits);
    check({tag, ".valid"}, 68'(output_valid), 68'd1);
    check({tag, ".idx"},   68'(Smin_index), 68'(idx));
    check({tag, ".sI1"},   68'(s_I_1), 68'(i1));
    check({tag, ".sQ1"},   68'(s_Q_1), 68'(q1));
    check({tag, ".sI2"},   68'(s_I_2), 68'(i2));
    check({tag, ".sQ2"},   68'(s_Q_2), 68'(q2));
    check({tag, ".bits"},  68'(signal_out_12bit), 68'(bits));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    H_in_valid = 1'b0; Y_in_valid = 1'b0;
    H_in_r = '0; H_in_i = '0; Y_in_r = '0; Y_in_i = '0;
    repeat (3) @(negedge clk);
    check("rst.valid", 68'(output_valid), 68'd0);
    check("rst.idx",   68'(Smin_index), 68'd0);
    check("rst.bits",  68'(signal_out_12bit), 68'd0);
    check("rst.sI1",   68'(s_I_1), 68'd0);
    check("rst.sQ2",   68'(s_Q_2), 68'd0);
    rst = 1'b1;

    // beats in IDLE must be ignored
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      H_in_valid = 1'b1; H_in_r = 32'h1234_5678; H_in_i = 32'h0765_4321;
      Y_in_valid = 1'b1; Y_in_r = 32'h0F00_0000; Y_in_i = 32'hF100_0000;
    end
    @(negedge clk);
    H_in_valid = 1'b0; Y_in_valid = 1'b0;

    // scenario 1: clean identity channel
    set_identity();
    set_y(P1, M3, P3, P3);
    pulse_start();
    load(0, 1'b0);
    wait_done("s1.lat");
    check_res("s1", 5'd9, P1, M3, P3, P3, 12'b100111001010);
`ifdef SOML_METRIC_OUT_EN
    check("s1.metric", min_metric, 68'd0);
`endif
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("s1.hold", 68'({output_valid, signal_out_12bit}), 68'({1'b1, 12'b100111001010}));
    end

    // start in DONE drops output_valid
    pulse_start();
    check("abort.valid", 68'(output_valid), 68'd0);

    // scenario 2: noisy slot-0 observation (1.2, -2.6)
    set_y(32'h004C_CCCD, 32'hFF59_999A, P3, P3);
    load(0, 1'b0);
    wait_done("s2.lat");
    check_res("s2", 5'd9, P1, M3, P3, P3, 12'b100111001010);

    // scenario 3: all-zero Y, every metric ties
    set_y(32'h0, 32'h0, 32'h0, 32'h0);
    pulse_start();
    load(0, 1'b0);
    wait_done("s3.lat");
    check_res("s3", 5'd0, P1, P1, P1, P1, 12'b000011111111);
`ifdef SOML_METRIC_OUT_EN
    check("s3.metric", min_metric, 68'h100_0000);
`endif

    // scenario 4: Y delayed 20 cycles after H
    set_y(P1, M3, P3, P3);
    pulse_start();
    load(20, 1'b0);
    wait_done("s4.lat");
    check_res("s4", 5'd9, P1, M3, P3, P3, 12'b100111001010);

    // scenario 5: reset during COMPUTE, then reload
    pulse_start();
    load(0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("s5.valid", 68'(output_valid), 68'd0);
    check("s5.idx",   68'(Smin_index), 68'd0);
    check("s5.bits",  68'(signal_out_12bit), 68'd0);
    check("s5.sQ1",   68'(s_Q_1), 68'd0);
    check("s5.sI2",   68'(s_I_2), 68'd0);
    rst = 1'b1;
    pulse_start();
    load(0, 1'b0);
    wait_done("s5.lat");
    check_res("s5r", 5'd9, P1, M3, P3, P3, 12'b100111001010);

    // scenario 6: 17th H beat ignored
    set_y(32'h0, 32'h0, 32'h0, 32'h0);
    pulse_start();
    load(0, 1'b1);
    wait_done("s6.lat");
    check_res("s6", 5'd0, P1, P1, P1, P1, 12'b000011111111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
